// File: rtl/ss_scan_driver_if.sv
// ss_scan_driver_if: bus between the datapath side (display word, load strobe,
// mode controls) and the scan driver, plus the pin-level outputs it returns.
interface ss_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] data;
   logic [N_DIGITS-1:0]   dp;
   logic [N_DIGITS-1:0]   blank;
   logic                  load;
   logic                  hex_en;
   logic                  lz_sup;
   logic [7:0]            segment;
   logic [N_DIGITS-1:0]   digit;
   logic                  frame_done;

   modport master (
      output data, dp, blank, load, hex_en, lz_sup,
      input  segment, digit, frame_done
   );

   modport slave (
      input  data, dp, blank, load, hex_en, lz_sup,
      output segment, digit, frame_done
   );
endinterface

// File: rtl/ss_scan_driver.sv
// ss_scan_driver: time-multiplexed N-digit 7-segment scanner.
// A shadow copy of the display word is taken on load; at every slot boundary
// the code for the next digit is decoded from the shadow and held for the whole
// slot, so a load never tears a digit mid-slot. Each slot opens with a guard
// interval where every digit is off, which hides ghosting while the segment
// lines settle. All pins are driven straight from flops; the pin flops are fed
// from the next-state values so they stay aligned with the slot counter.
module ss_scan_driver #(
   parameter int N_DIGITS       = 4,
   parameter int CLK_DIV        = 50000,
   parameter int GUARD_CYCLES   = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   ss_scan_driver_if.slave bus
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [N_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ?
                                             {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

   // Active-high segment code {a,b,c,d,e,f,g,dp}; letters only in hex mode.
   function automatic logic [7:0] f_decode(input logic [3:0] nib, input logic hex);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hFC;
         4'h1:    seg = 8'h60;
         4'h2:    seg = 8'hDA;
         4'h3:    seg = 8'hF2;
         4'h4:    seg = 8'h66;
         4'h5:    seg = 8'hB6;
         4'h6:    seg = 8'hBE;
         4'h7:    seg = 8'hE0;
         4'h8:    seg = 8'hFE;
         4'h9:    seg = 8'hF6;
         4'hA:    seg = hex ? 8'hEE : 8'h00;
         4'hB:    seg = hex ? 8'h3E : 8'h00;
         4'hC:    seg = hex ? 8'h9C : 8'h00;
         4'hD:    seg = hex ? 8'h7A : 8'h00;
         4'hE:    seg = hex ? 8'h9E : 8'h00;
         4'hF:    seg = hex ? 8'h8E : 8'h00;
         default: seg = 8'h00;
      endcase
      return seg;
   endfunction

   // shadow of the display word
   logic [4*N_DIGITS-1:0] r_sh_data;
   logic [N_DIGITS-1:0]   r_sh_dp;
   logic [N_DIGITS-1:0]   r_sh_blank;

   // scan position and the code held for the current slot
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_code;
   logic                  r_dark;

   // pin flops
   logic [7:0]            r_segment;
   logic [N_DIGITS-1:0]   r_digit;
   logic                  r_frame_done;

   logic                  w_wrap;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [3:0]            w_nib;
   logic                  w_sel_dp;
   logic                  w_sel_blk;
   logic                  w_upper_nz;
   logic [7:0]            w_new_code;
   logic                  w_new_dark;
   logic [7:0]            w_code_nxt;
   logic                  w_dark_nxt;
   logic                  w_guard;
   logic                  w_lit;
   logic [N_DIGITS-1:0]   w_onehot;
   logic [7:0]            w_seg_nxt;
   logic [N_DIGITS-1:0]   w_dig_nxt;
   logic                  w_fd_nxt;

   // Capture the display word on load; it only reaches the pins at a slot boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_data  <= {(4*N_DIGITS){1'b0}};
         r_sh_dp    <= {N_DIGITS{1'b0}};
         r_sh_blank <= {N_DIGITS{1'b1}};
      end else if (bus.load) begin
         r_sh_data  <= bus.data;
         r_sh_dp    <= bus.dp;
         r_sh_blank <= bus.blank;
      end else begin
         r_sh_data  <= r_sh_data;
         r_sh_dp    <= r_sh_dp;
         r_sh_blank <= r_sh_blank;
      end
   end

   // Slot counter and digit index advance; the index steps only when the slot wraps.
   always_comb begin
      w_wrap = (r_cnt == CNT_MAX);
      if (w_wrap) begin
         w_cnt_nxt = {CNT_W{1'b0}};
         w_idx_nxt = (r_idx == IDX_MAX) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
         w_idx_nxt = r_idx;
      end
   end

   // Decode the digit about to be scanned and decide whether it must stay dark.
   // Leading-zero suppression looks at this digit and every more significant one.
   always_comb begin
      w_nib      = 4'h0;
      w_sel_dp   = 1'b0;
      w_sel_blk  = 1'b0;
      w_upper_nz = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         w_nib      = (IDX_W'(i) == w_idx_nxt) ? r_sh_data[4*i +: 4] : w_nib;
         w_sel_dp   = (IDX_W'(i) == w_idx_nxt) ? r_sh_dp[i]          : w_sel_dp;
         w_sel_blk  = (IDX_W'(i) == w_idx_nxt) ? r_sh_blank[i]       : w_sel_blk;
         w_upper_nz = w_upper_nz |
                      ((IDX_W'(i) >= w_idx_nxt) & (r_sh_data[4*i +: 4] != 4'h0));
      end
      w_new_code = f_decode(w_nib, bus.hex_en) | {7'b0000000, w_sel_dp};
      w_new_dark = w_sel_blk |
                   (bus.lz_sup & (w_idx_nxt != {IDX_W{1'b0}}) & ~w_upper_nz & ~w_sel_dp);
   end

   // Guard interval: the first GUARD_CYCLES counts of every slot keep all digits off.
   generate
      if (GUARD_CYCLES > 0) begin : g_guard
         localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);
         assign w_guard = (w_cnt_nxt < GUARD_LIM);
      end else begin : g_no_guard
         assign w_guard = 1'b0;
      end
   endgenerate

   // Pin values for the coming cycle, with pin polarity applied last.
   always_comb begin
      w_code_nxt = w_wrap ? w_new_code : r_code;
      w_dark_nxt = w_wrap ? w_new_dark : r_dark;
      w_onehot   = {N_DIGITS{1'b0}};
      for (int i = 0; i < N_DIGITS; i++) begin
         w_onehot[i] = (IDX_W'(i) == w_idx_nxt);
      end
      w_lit     = ~w_guard & ~w_dark_nxt;
      w_seg_nxt = (w_lit ? w_code_nxt : 8'h00) ^ SEG_OFF;
      w_dig_nxt = (w_lit ? w_onehot : {N_DIGITS{1'b0}}) ^ DIG_OFF;
      w_fd_nxt  = (w_cnt_nxt == CNT_MAX) & (w_idx_nxt == IDX_MAX);
   end

   // Scan position and per-slot code; the code is refreshed only on a slot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_idx  <= {IDX_W{1'b0}};
         r_code <= 8'h00;
         r_dark <= 1'b1;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_idx  <= w_idx_nxt;
         r_code <= w_code_nxt;
         r_dark <= w_dark_nxt;
      end
   end

   // Register the pins so nothing combinational reaches the board.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_segment    <= SEG_OFF;
         r_digit      <= DIG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_segment    <= w_seg_nxt;
         r_digit      <= w_dig_nxt;
         r_frame_done <= w_fd_nxt;
      end
   end

   assign bus.segment    = r_segment;
   assign bus.digit      = r_digit;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ss_scan_driver.sv
// tb_ss_scan_driver: directed bench for the scan driver.
// Instance a: 4 digits, 8-cycle slots, 2-cycle guard, active-high pins.
// Instance b: same stimulus, both pin groups active-low.
// Instance c: single digit, 4-cycle slots, no guard.
// k counts rising edges since reset release, so slot count = k%8, digit = (k/8)%4.
module tb_ss_scan_driver;

   logic clk = 1'b0;
   logic rst_n;
   int   k;
   int   n_chk = 0;
   int   n_bad = 0;
   int   fd_cnt;

   always #5 clk = ~clk;

   ss_scan_driver_if #(.N_DIGITS(4)) bus_a ();
   ss_scan_driver_if #(.N_DIGITS(4)) bus_b ();
   ss_scan_driver_if #(.N_DIGITS(1)) bus_c ();

   assign bus_b.data   = bus_a.data;
   assign bus_b.dp     = bus_a.dp;
   assign bus_b.blank  = bus_a.blank;
   assign bus_b.load   = bus_a.load;
   assign bus_b.hex_en = bus_a.hex_en;
   assign bus_b.lz_sup = bus_a.lz_sup;

   ss_scan_driver #(.N_DIGITS(4), .CLK_DIV(8), .GUARD_CYCLES(2),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
      u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

   ss_scan_driver #(.N_DIGITS(4), .CLK_DIV(8), .GUARD_CYCLES(2),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
      u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   ss_scan_driver #(.N_DIGITS(1), .CLK_DIV(4), .GUARD_CYCLES(0),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
      u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      k++;
      #1;
   endtask

   // Expected {frame_done, digit, segment} of instance a at edge count kk.
   // codes holds the hand-decoded segment byte of digit i at [8i+7:8i].
   function automatic logic [12:0] exp_a(input int kk, input logic [31:0] codes,
                                         input logic [3:0] dark);
      int          c;
      int          ix;
      logic [12:0] r;
      c     = kk % 8;
      ix    = (kk / 8) % 4;
      r     = 13'h0000;
      r[12] = (c == 7) && (ix == 3);
      if ((c >= 2) && !dark[ix]) begin
         r[11:8] = 4'b0001 << ix;
         r[7:0]  = codes[8*ix +: 8];
      end
      return r;
   endfunction

   task automatic chk_cycle(input string tag, input logic [31:0] codes, input logic [3:0] dark);
      logic [12:0] e;
      e = exp_a(k, codes, dark);
      chk({tag, "_a"}, 32'({bus_a.frame_done, bus_a.digit, bus_a.segment}), 32'(e));
      chk({tag, "_b"}, 32'({bus_b.frame_done, bus_b.digit, bus_b.segment}), 32'(e ^ 13'h0FFF));
   endtask

   // Check one whole frame; must be entered with k%32 == 0.
   task automatic run_frame(input string tag, input logic [31:0] codes, input logic [3:0] dark);
      repeat (32) begin
         chk_cycle(tag, codes, dark);
         tick();
      end
   endtask

   // Load a word, then move to the next frame start whose slots all use it.
   task automatic load_word(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                            input logic h, input logic lz);
      bus_a.data   = d;
      bus_a.dp     = p;
      bus_a.blank  = b;
      bus_a.hex_en = h;
      bus_a.lz_sup = lz;
      bus_a.load   = 1'b1;
      tick();
      bus_a.load   = 1'b0;
      do tick(); while (k % 32 != 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog k=%0d", k);
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      k            = 0;
      bus_a.data   = 16'h0000;
      bus_a.dp     = 4'h0;
      bus_a.blank  = 4'h0;
      bus_a.load   = 1'b0;
      bus_a.hex_en = 1'b0;
      bus_a.lz_sup = 1'b0;
      bus_c.data   = 4'h0;
      bus_c.dp     = 1'b0;
      bus_c.blank  = 1'b0;
      bus_c.load   = 1'b0;
      bus_c.hex_en = 1'b0;
      bus_c.lz_sup = 1'b0;

      #12;
      chk("rst_a", 32'({bus_a.frame_done, bus_a.digit, bus_a.segment}), 32'h0000);
      chk("rst_b", 32'({bus_b.frame_done, bus_b.digit, bus_b.segment}), 32'h0FFF);
      rst_n = 1'b1;

      // no load yet: everything dark, frame_done still marks the frame
      run_frame("idle", 32'h0000_0000, 4'b1111);
      // decimal 1234
      load_word(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);
      run_frame("dec", 32'h60DA_F266, 4'b0000);
      // hex with a decimal point on digit 2
      load_word(16'hA0F9, 4'b0100, 4'b0000, 1'b1, 1'b0);
      run_frame("hex", 32'hEEFD_8EF6, 4'b0000);
      // same word in decimal mode: letters go blank but digits stay enabled
      load_word(16'hA0F9, 4'b0100, 4'b0000, 1'b0, 1'b0);
      run_frame("nohex", 32'h00FD_00F6, 4'b0000);
      // leading-zero suppression
      load_word(16'h0050, 4'b0000, 4'b0000, 1'b0, 1'b1);
      run_frame("lz50", 32'h0000_B6FC, 4'b1100);
      load_word(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
      run_frame("lz00", 32'h0000_00FC, 4'b1110);
      // a decimal point keeps its own zero digit lit
      load_word(16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1);
      run_frame("lzdp", 32'h00FD_00FC, 4'b1010);
      // blank hides both segments and dp
      load_word(16'h8888, 4'b0010, 4'b0010, 1'b0, 1'b0);
      run_frame("blank", 32'hFEFE_FFFE, 4'b0010);

      // load on the same edge as a slot wrap
      load_word(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);
      run_frame("dec2", 32'h60DA_F266, 4'b0000);
      repeat (7) tick();
      bus_a.data = 16'h5678;
      bus_a.load = 1'b1;
      tick();
      bus_a.load = 1'b0;
      repeat (8) begin
         chk_cycle("same_old", 32'h60DA_F266, 4'b0000);
         tick();
      end
      repeat (8) begin
         chk_cycle("same_new", 32'hB6BE_E0FE, 4'b0000);
         tick();
      end

      // asynchronous reset in slot idx=2 at cnt=5
      do tick(); while (k % 32 != 21);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a", 32'({bus_a.frame_done, bus_a.digit, bus_a.segment}), 32'h0000);
      chk("mid_rst_b", 32'({bus_b.frame_done, bus_b.digit, bus_b.segment}), 32'h0FFF);
      @(posedge clk);
      #1;
      chk("hold_rst_a", 32'({bus_a.frame_done, bus_a.digit, bus_a.segment}), 32'h0000);
      #2;
      rst_n = 1'b1;
      k     = 0;
      run_frame("post_rst", 32'h0000_0000, 4'b1111);
      load_word(16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0);
      run_frame("reload", 32'h66F2_DA60, 4'b0000);

      // single-digit build, no guard: always lit, frame_done every 4 cycles
      bus_c.data = 4'h7;
      bus_c.load = 1'b1;
      tick();
      bus_c.load = 1'b0;
      do tick(); while (k % 4 != 0);
      fd_cnt = 0;
      repeat (16) begin
         chk("one_dig", 32'({bus_c.frame_done, bus_c.digit, bus_c.segment}),
             32'({(k % 4) == 3, 1'b1, 8'hE0}));
         if (bus_c.frame_done) fd_cnt++;
         tick();
      end
      chk("one_fd_cnt", 32'(fd_cnt), 32'd4);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-segment 7-segment display. Captures a packed nibble word into a shadow register, decodes each digit (decimal or hex mode) to the team's 8-bit segment code, and scans digits one at a time with a programmable slot length and an anti-ghosting guard interval. Sits between the datapath/counter blocks and the board's segment and digit-enable pins; it generalises the combinational single-digit decoder to a clocked, multi-digit scanner.

Parameters:
N_DIGITS, 4, number of digits scanned (legal 1..8)
CLK_DIV, 50000, clock cycles per digit slot (legal >= 2)
GUARD_CYCLES, 1, cycles at the start of each slot with all digits off (legal 0..CLK_DIV-1)
SEG_ACTIVE_LOW, 0, 1 inverts segment[7:0] at the pins
DIG_ACTIVE_LOW, 0, 1 inverts digit[N_DIGITS-1:0] at the pins

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
data  in  4*N_DIGITS  packed nibbles; data[4i+3:4i] is digit i (i=0 rightmost)
dp  in  N_DIGITS  decimal point per digit
blank  in  N_DIGITS  force digit i dark
load  in  1  capture data/dp/blank into shadow register
hex_en  in  1  1: nibbles 10..15 show A b C d E F; 0: show dark
lz_sup  in  1  leading-zero suppression enable
segment  out  8  segment code {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp
digit  out  N_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at end of digit N_DIGITS-1 slot

Behaviour:
- Reset (rst_n low, async): shadow data=0, dp=0, blank=all 1s; slot counter cnt=0; digit index idx=0; latched slot code=dark; segment=inactive (0x00, or 0xFF if SEG_ACTIVE_LOW); digit=all inactive; frame_done=0. Reset mid-scan aborts immediately; scan restarts at idx 0, cnt 0 on the first edge after release.
- Shadow: on edge with load=1, shadow <= {data, dp, blank}; visible from the next slot boundary (no tearing within a slot). hex_en and lz_sup are sampled at slot boundaries only.
- Counter: cnt increments every cycle, wraps CLK_DIV-1 -> 0. On the wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1, and the slot code for the new idx is latched from the shadow.
- Phase: GUARD while cnt < GUARD_CYCLES (digit all inactive, segment inactive); DRIVE otherwise (digit = one-hot(idx) unless slot code is dark, in which case digit inactive and segment inactive).
- All outputs come from registers; no combinational path from inputs to pins.
- Decode (active-high, before polarity): 0=0xFC 1=0x60 2=0xDA 3=0xF2 4=0x66 5=0xB6 6=0xBE 7=0xE0 8=0xFE 9=0xF6 A=0xEE b=0x3E C=0x9C d=0x7A E=0x9E F=0x8E; dp ORs 0x01. Nibble >= 10 with hex_en=0 decodes to 0x00 (dp still applied).
- Dark rule: digit i is dark if blank[i], or lz_sup=1 and i != 0 and nibbles i..N_DIGITS-1 are all zero and dp[i]=0. Digit 0 is never suppressed by lz_sup. A dark digit shows neither segments nor dp.
- frame_done: 1 for exactly one cycle, the cycle the shadow-driven wrap from idx N_DIGITS-1 to 0 occurs (cnt wrap with idx=N_DIGITS-1).
- N_DIGITS=1: idx stays 0; frame_done pulses every CLK_DIV cycles.
- GUARD_CYCLES=0: no guard; digit asserted for all CLK_DIV cycles of a slot.
- load and a slot boundary on the same edge: the new slot latches the OLD shadow; new data appears one slot later.

Test Plan:
- N_DIGITS=4, CLK_DIV=8, GUARD_CYCLES=2; reset then no load -> segment=0x00, digit=0000 for all cycles; frame_done pulses every 32 cycles.
- load data=0x1234, dp=0, blank=0, hex_en=0 -> per slot: 2 cycles digit=0000, then 6 cycles digit=0001/seg 0x66, 0010/0xF2, 0100/0xDA, 1000/0x60 in order.
- hex_en=1, data=0xA0F9, dp=0b0100 -> digit2 seg 0x01|0x3C? no: digit2 nibble 0 -> 0xFD; digit3 0xEE; digit1 0x8E; digit0 0xF6. With hex_en=0 digits 3 and 1 show 0x00.
- lz_sup=1, data=0x0050 -> digit3 dark, digit2 dark, digit1 0xB6, digit0 0xFC; data=0x0000 -> only digit0 lit 0xFC.
- load asserted on the same edge as a slot wrap -> the starting slot shows the old value; the following slot shows the new value; no mid-slot segment change.
- rst_n pulled low mid-slot (idx=2, cnt=5) -> outputs inactive asynchronously; after release, idx=0 slot starts at cnt=0 and the display stays dark until the next load; SEG_ACTIVE_LOW=1 build shows segment=0xFF while dark.
